// File: rtl/console_pkg.sv
// Shared constants for the text console write controller: screen geometry, control
// characters, register decode and FSM state encodings.
package console_pkg;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 60;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_BS = 8'h08;

  localparam logic [15:0] BLANK = 16'h0020;

  // ADDR bit selecting the control register (1) over the data register (0)
  localparam int unsigned REG_SEL_BIT = 2;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StPut   = 3'd1;
  localparam state_t StScrRd = 3'd2;
  localparam state_t StScrWr = 3'd3;
  localparam state_t StFill  = 3'd4;
  localparam state_t StClr   = 3'd5;
  localparam state_t StDone  = 3'd6;

endpackage

// File: rtl/text_console_ctrl.sv
// Terminal-style write controller: turns CPU character/control writes into frame-buffer
// cell writes, owns the cursor and runs scroll/clear sequences before acknowledging.
module text_console_ctrl #(
  parameter int unsigned COLS  = console_pkg::COLS,
  parameter int unsigned ROWS  = console_pkg::ROWS,
  parameter logic [15:0] BLANK = console_pkg::BLANK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic        ACK,
  output logic [12:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y,
  output logic        busy
);
  import console_pkg::state_t;
  import console_pkg::StIdle;
  import console_pkg::StPut;
  import console_pkg::StScrRd;
  import console_pkg::StScrWr;
  import console_pkg::StFill;
  import console_pkg::StClr;
  import console_pkg::StDone;
  import console_pkg::CHAR_LF;
  import console_pkg::CHAR_CR;
  import console_pkg::CHAR_BS;
  import console_pkg::REG_SEL_BIT;

  localparam int unsigned Cells       = COLS * ROWS;
  localparam int unsigned ScrollCells = Cells - COLS;

  localparam logic [12:0] RowStride  = 13'(COLS);
  localparam logic [12:0] LastCell   = 13'(Cells - 1);
  localparam logic [12:0] LastScroll = 13'(ScrollCells - 1);
  localparam logic [12:0] LastFill   = 13'(COLS - 1);
  localparam logic [12:0] FillBase   = 13'(ScrollCells);
  localparam logic [6:0]  LastCol    = 7'(COLS - 1);
  localparam logic [5:0]  LastRow    = 6'(ROWS - 1);

  state_t      state_q, state_d;
  logic [6:0]  cx_q, cx_d;
  logic [5:0]  cy_q, cy_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] put_addr_q, put_addr_d;
  logic [15:0] put_data_q, put_data_d;
  logic        bs_q, bs_d;

  logic [7:0]  cmd_char;
  logic [6:0]  set_col;
  logic [5:0]  set_row;
  logic        unused_bits;

  assign cmd_char    = DAT_I[7:0];
  assign set_col     = DAT_I[14:8];
  assign set_row     = DAT_I[21:16];
  assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:22]};

  function automatic logic [12:0] cell_idx(input logic [5:0] row, input logic [6:0] col);
    return 13'(row) * RowStride + 13'(col);
  endfunction

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    cnt_d      = cnt_q;
    put_addr_d = put_addr_q;
    put_data_d = put_data_q;
    bs_d       = bs_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (STB) begin
          if (!ADDR[REG_SEL_BIT]) begin
            if (cmd_char == CHAR_LF) begin
              cx_d = '0;
              if (cy_q == LastRow) begin
                state_d = StScrRd;
              end else begin
                cy_d    = cy_q + 6'd1;
                state_d = StDone;
              end
            end else if (cmd_char == CHAR_CR) begin
              cx_d    = '0;
              state_d = StDone;
            end else if (cmd_char == CHAR_BS) begin
              if (cx_q == '0) begin
                state_d = StDone;
              end else begin
                put_addr_d = cell_idx(cy_q, cx_q - 7'd1);
                put_data_d = BLANK;
                bs_d       = 1'b1;
                state_d    = StPut;
              end
            end else begin
              put_addr_d = cell_idx(cy_q, cx_q);
              put_data_d = DAT_I[15:0];
              bs_d       = 1'b0;
              state_d    = StPut;
            end
          end else begin
            // Clear wins over cursor-set when both bits are written together
            if (DAT_I[0]) begin
              cx_d    = '0;
              cy_d    = '0;
              state_d = StClr;
            end else begin
              if (DAT_I[1] && set_col <= LastCol && set_row <= LastRow) begin
                cx_d = set_col;
                cy_d = set_row;
              end
              state_d = StDone;
            end
          end
        end
      end
      StPut: begin
        state_d = StDone;
        if (bs_q) begin
          cx_d = cx_q - 7'd1;
        end else if (cx_q == LastCol) begin
          cx_d = '0;
          if (cy_q == LastRow) begin
            state_d = StScrRd;
          end else begin
            cy_d = cy_q + 6'd1;
          end
        end else begin
          cx_d = cx_q + 7'd1;
        end
      end
      StScrRd: state_d = StScrWr;
      StScrWr: begin
        if (cnt_q == LastScroll) begin
          cnt_d   = '0;
          state_d = StFill;
        end else begin
          cnt_d   = cnt_q + 13'd1;
          state_d = StScrRd;
        end
      end
      StFill: begin
        if (cnt_q == LastFill) state_d = StDone;
        else cnt_d = cnt_q + 13'd1;
      end
      StClr: begin
        if (cnt_q == LastCell) state_d = StDone;
        else cnt_d = cnt_q + 13'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cx_q       <= '0;
      cy_q       <= '0;
      cnt_q      <= '0;
      put_addr_q <= '0;
      put_data_q <= '0;
      bs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      cnt_q      <= cnt_d;
      put_addr_q <= put_addr_d;
      put_data_q <= put_data_d;
      bs_q       <= bs_d;
    end
  end

  // Scroll reads the source a row below; its data arrives during the following write cycle
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StPut: begin
        mem_we    = 1'b1;
        mem_addr  = put_addr_q;
        mem_wdata = put_data_q;
      end
      StScrRd: mem_addr = cnt_q + RowStride;
      StScrWr: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = mem_rdata;
      end
      StFill: begin
        mem_we    = 1'b1;
        mem_addr  = FillBase + cnt_q;
        mem_wdata = BLANK;
      end
      StClr: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = BLANK;
      end
      default: ;
    endcase
  end

  assign ACK      = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign cursor_x = cx_q;
  assign cursor_y = cy_q;

endmodule
